// File: rtl/irq_nest_ctrl_if.sv
// irq_nest_ctrl_if
// Bundles the controller-facing arbitration/claim signals, the core-facing
// trap handshake and the nesting status outputs of irq_nest_ctrl.
// The slave modport is the view of irq_nest_ctrl itself; the master modport
// is the view of whatever drives it (controller plus core, or a testbench).

interface irq_nest_ctrl_if #(
    parameter int NrIrqLines = 64,
    parameter int NrIrqPrios = 32,
    parameter int StackDepth = 4
) ();

    localparam int IrqWidth   = $clog2(NrIrqLines);
    localparam int PrioWidth  = $clog2(NrIrqPrios);
    localparam int DepthWidth = $clog2(StackDepth + 1);

    // controller arbitration result
    logic                  irq_valid_i;
    logic [IrqWidth-1:0]   irq_id_i;
    logic [PrioWidth-1:0]  irq_level_i;
    logic                  irq_heti_i;
    logic                  irq_nest_i;

    // claim back to the controller
    logic                  irq_ack_o;
    logic [IrqWidth-1:0]   irq_id_o;

    // core trap handshake
    logic                  core_mie_i;
    logic                  core_irq_req_o;
    logic [IrqWidth-1:0]   core_irq_id_o;
    logic                  core_irq_heti_o;
    logic                  core_irq_gnt_i;
    logic                  core_mret_i;

    // nesting status
    logic [PrioWidth-1:0]  level_o;
    logic [DepthWidth-1:0] depth_o;
    logic [DepthWidth-1:0] max_depth_o;

    modport slave (
        input  irq_valid_i,
        input  irq_id_i,
        input  irq_level_i,
        input  irq_heti_i,
        input  irq_nest_i,
        output irq_ack_o,
        output irq_id_o,
        input  core_mie_i,
        output core_irq_req_o,
        output core_irq_id_o,
        output core_irq_heti_o,
        input  core_irq_gnt_i,
        input  core_mret_i,
        output level_o,
        output depth_o,
        output max_depth_o
    );

    modport master (
        output irq_valid_i,
        output irq_id_i,
        output irq_level_i,
        output irq_heti_i,
        output irq_nest_i,
        input  irq_ack_o,
        input  irq_id_o,
        output core_mie_i,
        input  core_irq_req_o,
        input  core_irq_id_o,
        input  core_irq_heti_o,
        output core_irq_gnt_i,
        output core_mret_i,
        input  level_o,
        input  depth_o,
        input  max_depth_o
    );

endinterface

// File: rtl/irq_nest_ctrl.sv
// irq_nest_ctrl
// Core-side consumer of the interrupt controller's arbitration result.
// A winning line whose priority is strictly above the running level is
// latched and presented to the core as a trap request; the core's grant
// claims the line back to the controller and pushes the new level onto a
// small nesting stack that mret pops.
//
// Optional feature macro: IRQ_NEST_CTRL_WATERMARK_EN
//   defined   -> max_depth_o holds the highest stack occupancy since reset
//   undefined -> max_depth_o is tied to zero, no register is built

module irq_nest_ctrl #(
    parameter int NrIrqLines = 64,
    parameter int NrIrqPrios = 32,
    parameter int StackDepth = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    irq_nest_ctrl_if.slave bus
);

    localparam int IrqWidth   = $clog2(NrIrqLines);
    localparam int PrioWidth  = $clog2(NrIrqPrios);
    localparam int DepthWidth = $clog2(StackDepth + 1);
    localparam int IdxWidth   = (StackDepth > 1) ? $clog2(StackDepth) : 1;

    localparam logic [DepthWidth-1:0] DepthMax = DepthWidth'(StackDepth);
    localparam logic [DepthWidth-1:0] DepthOne = DepthWidth'(1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAck
    } state_e;

    state_e                state_q;

    // request latched at take time, held unchanged until the grant
    logic [IrqWidth-1:0]   lat_id_q;
    logic [PrioWidth-1:0]  lat_level_q;
    logic                  lat_heti_q;
    logic                  lat_nest_q;

    // registered handshake outputs
    logic                  req_q;
    logic                  ack_q;
    logic [IrqWidth-1:0]   ack_id_q;

    // nesting stack, entry i valid while i < depth_q
    logic [PrioWidth-1:0]  stk_level_q [StackDepth];
    logic                  stk_nest_q  [StackDepth];
    logic [DepthWidth-1:0] depth_q;

    logic [IdxWidth-1:0]   top_idx;
    logic [IdxWidth-1:0]   push_idx;
    logic [PrioWidth-1:0]  cur_level;
    logic                  nestable;
    logic                  take;
    logic                  pop;
    logic                  push;
    logic [DepthWidth-1:0] depth_pop;
    logic [DepthWidth-1:0] depth_d;

    // Current running level and nest permission come from the top entry;
    // an empty stack means thread level, which anything above 0 may preempt.
    always_comb begin
        top_idx   = IdxWidth'(depth_q - DepthOne);
        cur_level = '0;
        nestable  = 1'b1;
        if (depth_q != '0) begin
            cur_level = stk_level_q[top_idx];
            nestable  = stk_nest_q[top_idx];
        end
    end

    // Take decision plus the stack update; a same-cycle mret pops before the
    // grant pushes, so the new entry lands on the slot that was just freed.
    always_comb begin
        take      = bus.irq_valid_i & bus.core_mie_i &
                    (bus.irq_level_i > cur_level) & nestable &
                    (depth_q < DepthMax);
        pop       = bus.core_mret_i & (depth_q != '0);
        depth_pop = depth_q - DepthWidth'(pop);
        push      = (state_q == StReq) & bus.core_irq_gnt_i &
                    (depth_pop < DepthMax);
        push_idx  = IdxWidth'(depth_pop);
        depth_d   = push ? (depth_pop + DepthOne) : depth_pop;
    end

    // Request/claim sequencer: latch on take, hold until grant, then a
    // single claim cycle that also gives the controller time to clear ip.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            lat_id_q    <= '0;
            lat_level_q <= '0;
            lat_heti_q  <= 1'b0;
            lat_nest_q  <= 1'b0;
            req_q       <= 1'b0;
            ack_q       <= 1'b0;
            ack_id_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    ack_q    <= 1'b0;
                    ack_id_q <= '0;
                    if (take) begin
                        lat_id_q    <= bus.irq_id_i;
                        lat_level_q <= bus.irq_level_i;
                        lat_heti_q  <= bus.irq_heti_i;
                        lat_nest_q  <= bus.irq_nest_i;
                        req_q       <= 1'b1;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (bus.core_irq_gnt_i) begin
                        req_q    <= 1'b0;
                        ack_q    <= 1'b1;
                        ack_id_q <= lat_id_q;
                        state_q  <= StAck;
                    end
                end
                StAck: begin
                    ack_q    <= 1'b0;
                    ack_id_q <= '0;
                    state_q  <= StIdle;
                end
                default: begin
                    req_q   <= 1'b0;
                    ack_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Level stack storage and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < StackDepth; i++) begin
                stk_level_q[i] <= '0;
                stk_nest_q[i]  <= 1'b0;
            end
            depth_q <= '0;
        end else begin
            if (push) begin
                stk_level_q[push_idx] <= lat_level_q;
                stk_nest_q[push_idx]  <= lat_nest_q;
            end
            depth_q <= depth_d;
        end
    end

`ifdef IRQ_NEST_CTRL_WATERMARK_EN
    logic [DepthWidth-1:0] max_depth_q;

    // High watermark follows the next occupancy so it moves with depth_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_depth_q <= '0;
        end else if (depth_d > max_depth_q) begin
            max_depth_q <= depth_d;
        end
    end

    assign bus.max_depth_o = max_depth_q;
`else
    assign bus.max_depth_o = '0;
`endif

    assign bus.irq_ack_o       = ack_q;
    assign bus.irq_id_o        = ack_id_q;
    assign bus.core_irq_req_o  = req_q;
    assign bus.core_irq_id_o   = lat_id_q;
    assign bus.core_irq_heti_o = lat_heti_q;
    assign bus.level_o         = cur_level;
    assign bus.depth_o         = depth_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// tb_irq_nest_ctrl
// Directed bench for irq_nest_ctrl. Expected trap requests and claims are
// queued when the stimulus is applied and popped when the DUT shows them.
// Honours IRQ_NEST_CTRL_WATERMARK_EN for the expected max_depth_o value.

module tb_irq_nest_ctrl;

    typedef struct packed {
        logic [5:0] id;
        logic       heti;
    } req_t;

    logic clk;
    logic rst;

    int checks;
    int errors;

    req_t       req_sb[$];
    logic [5:0] ack_sb[$];

`ifdef IRQ_NEST_CTRL_WATERMARK_EN
    localparam int ExpMaxFull = 4;
`else
    localparam int ExpMaxFull = 0;
`endif

    irq_nest_ctrl_if ifc ();

    irq_nest_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    // free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input int id, input int level,
                                 input logic heti, input logic nest);
        ifc.irq_valid_i = valid;
        ifc.irq_id_i    = 6'(id);
        ifc.irq_level_i = 5'(level);
        ifc.irq_heti_i  = heti;
        ifc.irq_nest_i  = nest;
    endtask

    // wait (bounded) for a trap request and compare it to the scoreboard head
    task automatic waitReq(input string tag);
        int   n;
        req_t exp_r;
        n = 0;
        while (ifc.core_irq_req_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        exp_r = '0;
        if (req_sb.size() > 0) exp_r = req_sb.pop_front();
        checkOutput({tag, "_seen"}, 32'(ifc.core_irq_req_o), 32'd1);
        checkOutput({tag, "_id"}, 32'(ifc.core_irq_id_o), 32'(exp_r.id));
        checkOutput({tag, "_heti"}, 32'(ifc.core_irq_heti_o), 32'(exp_r.heti));
    endtask

    // hold the current inputs and require that no request appears
    task automatic noReq(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ifc.core_irq_req_o !== 1'b0) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd0);
    endtask

    // grant (optionally with mret) and check the one-cycle claim pulse
    task automatic grantAndCheck(input int ack_id, input logic with_mret,
                                 input string tag);
        logic [5:0] exp_id;
        ack_sb.push_back(6'(ack_id));
        ifc.core_irq_gnt_i = 1'b1;
        ifc.core_mret_i    = with_mret;
        tick();
        ifc.core_irq_gnt_i = 1'b0;
        ifc.core_mret_i    = 1'b0;
        exp_id = '0;
        if (ack_sb.size() > 0) exp_id = ack_sb.pop_front();
        checkOutput({tag, "_ack"}, 32'(ifc.irq_ack_o), 32'd1);
        checkOutput({tag, "_ack_id"}, 32'(ifc.irq_id_o), 32'(exp_id));
        checkOutput({tag, "_req_low"}, 32'(ifc.core_irq_req_o), 32'd0);
        tick();
        checkOutput({tag, "_ack_end"}, 32'(ifc.irq_ack_o), 32'd0);
    endtask

    task automatic mretPulse();
        ifc.core_mret_i = 1'b1;
        tick();
        ifc.core_mret_i = 1'b0;
    endtask

    task automatic checkLevelDepth(input string tag, input int level, input int depth);
        checkOutput({tag, "_level"}, 32'(ifc.level_o), 32'(level));
        checkOutput({tag, "_depth"}, 32'(ifc.depth_o), 32'(depth));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        ifc.core_mie_i     = 1'b1;
        ifc.core_irq_gnt_i = 1'b0;
        ifc.core_mret_i    = 1'b0;

        // reset state
        tick();
        tick();
        checkOutput("rst_req", 32'(ifc.core_irq_req_o), 32'd0);
        checkOutput("rst_ack", 32'(ifc.irq_ack_o), 32'd0);
        checkOutput("rst_max", 32'(ifc.max_depth_o), 32'd0);
        checkLevelDepth("rst", 0, 0);
        rst = 1'b0;
        tick();

        // basic take, grant and claim
        $display("[TB] basic request");
        applyStimulus(1'b1, 5, 3, 1'b0, 1'b1);
        req_sb.push_back('{id: 6'd5, heti: 1'b0});
        waitReq("b_req");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        grantAndCheck(5, 1'b0, "b_gnt");
        checkLevelDepth("b_run", 3, 1);

        // nested preemption, then the g+3 earliest re-request
        $display("[TB] nesting");
        applyStimulus(1'b1, 9, 7, 1'b0, 1'b1);
        req_sb.push_back('{id: 6'd9, heti: 1'b0});
        waitReq("c_req");
        applyStimulus(1'b1, 11, 9, 1'b0, 1'b0);
        grantAndCheck(9, 1'b0, "c_gnt");
        checkLevelDepth("c_run", 7, 2);
        checkOutput("c_req_g2", 32'(ifc.core_irq_req_o), 32'd0);
        tick();
        checkOutput("c_req_g3", 32'(ifc.core_irq_req_o), 32'd1);
        req_sb.push_back('{id: 6'd11, heti: 1'b0});
        waitReq("c_req11");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        grantAndCheck(11, 1'b0, "c_gnt11");
        checkLevelDepth("c_run11", 9, 3);

        // top entry not nestable: higher line must be ignored
        applyStimulus(1'b1, 12, 15, 1'b0, 1'b1);
        noReq("c_nonest", 10);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        mretPulse();
        checkLevelDepth("c_pop", 7, 2);

        // equal and lower levels are not taken; mret exposes the lower one
        $display("[TB] priority compare");
        applyStimulus(1'b1, 2, 7, 1'b0, 1'b1);
        noReq("d_equal", 8);
        applyStimulus(1'b1, 2, 4, 1'b0, 1'b1);
        noReq("d_lower", 8);
        req_sb.push_back('{id: 6'd2, heti: 1'b0});
        mretPulse();
        checkLevelDepth("d_pop", 3, 1);
        waitReq("d_req");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        grantAndCheck(2, 1'b0, "d_gnt");
        checkLevelDepth("d_run", 4, 2);

        // drain, then mret on an empty stack
        mretPulse();
        mretPulse();
        checkLevelDepth("e_empty", 0, 0);
        mretPulse();
        checkLevelDepth("e_under", 0, 0);

        // fill to full depth, full stack blocks further requests
        $display("[TB] full stack");
        for (int lvl = 1; lvl <= 4; lvl++) begin
            applyStimulus(1'b1, lvl, lvl, 1'b0, 1'b1);
            req_sb.push_back('{id: 6'(lvl), heti: 1'b0});
            waitReq($sformatf("f_req%0d", lvl));
            applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
            grantAndCheck(lvl, 1'b0, $sformatf("f_gnt%0d", lvl));
        end
        checkLevelDepth("f_full", 4, 4);
        applyStimulus(1'b1, 20, 5, 1'b0, 1'b1);
        noReq("f_blocked", 10);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        checkOutput("f_depth_hold", 32'(ifc.depth_o), 32'd4);
        checkOutput("f_max", 32'(ifc.max_depth_o), 32'(ExpMaxFull));
        for (int i = 0; i < 4; i++) mretPulse();
        checkLevelDepth("f_drain", 0, 0);
        mretPulse();
        checkOutput("f_under", 32'(ifc.depth_o), 32'd0);
        checkOutput("f_max_keep", 32'(ifc.max_depth_o), 32'(ExpMaxFull));

        // latched request survives input changes; grant with mret swaps top
        $display("[TB] latched request");
        applyStimulus(1'b1, 30, 2, 1'b0, 1'b1);
        req_sb.push_back('{id: 6'd30, heti: 1'b0});
        waitReq("g_req30");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        grantAndCheck(30, 1'b0, "g_gnt30");
        applyStimulus(1'b1, 31, 6, 1'b1, 1'b1);
        req_sb.push_back('{id: 6'd31, heti: 1'b1});
        waitReq("g_req31");
        applyStimulus(1'b1, 40, 20, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("g_hold_id", 32'(ifc.core_irq_id_o), 32'd31);
        checkOutput("g_hold_req", 32'(ifc.core_irq_req_o), 32'd1);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        checkOutput("g_drop_id", 32'(ifc.core_irq_id_o), 32'd31);
        checkOutput("g_drop_req", 32'(ifc.core_irq_req_o), 32'd1);
        grantAndCheck(31, 1'b1, "g_swap");
        checkLevelDepth("g_swap_run", 6, 1);

        // reset while requesting
        $display("[TB] reset in REQ");
        applyStimulus(1'b1, 50, 10, 1'b1, 1'b1);
        req_sb.push_back('{id: 6'd50, heti: 1'b1});
        waitReq("h_req");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("h_rst_req", 32'(ifc.core_irq_req_o), 32'd0);
        checkOutput("h_rst_id", 32'(ifc.core_irq_id_o), 32'd0);
        checkOutput("h_rst_heti", 32'(ifc.core_irq_heti_o), 32'd0);
        checkOutput("h_rst_max", 32'(ifc.max_depth_o), 32'd0);
        checkLevelDepth("h_rst", 0, 0);
        tick();
        rst = 1'b0;
        tick();
        checkLevelDepth("h_after", 0, 0);
        applyStimulus(1'b1, 51, 3, 1'b0, 1'b1);
        req_sb.push_back('{id: 6'd51, heti: 1'b0});
        waitReq("h_idle_req");

        // reset during the claim cycle
        $display("[TB] reset in ACK");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        ifc.core_irq_gnt_i = 1'b1;
        tick();
        ifc.core_irq_gnt_i = 1'b0;
        checkOutput("i_ack_pre", 32'(ifc.irq_ack_o), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("i_rst_ack", 32'(ifc.irq_ack_o), 32'd0);
        checkOutput("i_rst_ackid", 32'(ifc.irq_id_o), 32'd0);
        checkLevelDepth("i_rst", 0, 0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("i_after_req", 32'(ifc.core_irq_req_o), 32'd0);
        checkOutput("i_after_ack", 32'(ifc.irq_ack_o), 32'd0);
        checkLevelDepth("i_after", 0, 0);

        // every queued expectation must have been consumed
        checkOutput("sb_req_left", 32'(req_sb.size()), 32'd0);
        checkOutput("sb_ack_left", 32'(ack_sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
